// File: rtl/ex_mem_pipe_reg.sv
// EX->MEM pipeline register with valid/ready handshake, 2-entry skid buffer,
// synchronous flush and optional suppression of register-file writes to $0.
module ex_mem_pipe_reg #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter bit ZERO_REG_SUPP  = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_reg_write,
    input  logic                      in_jump_reg,
    input  logic [DATA_WIDTH-1:0]     in_pc,
    input  logic                      in_zero,
    input  logic [DATA_WIDTH-1:0]     in_result,
    input  logic [DATA_WIDTH-1:0]     in_data2,
    input  logic [REG_ADDR_WIDTH-1:0] in_write_addr,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_reg_write,
    output logic                      out_jump_reg,
    output logic [DATA_WIDTH-1:0]     out_pc,
    output logic                      out_zero,
    output logic [DATA_WIDTH-1:0]     out_result,
    output logic [DATA_WIDTH-1:0]     out_data2,
    output logic [REG_ADDR_WIDTH-1:0] out_write_addr
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0]     pc;
        logic                      zero;
        logic [DATA_WIDTH-1:0]     result;
        logic [DATA_WIDTH-1:0]     data2;
        logic [REG_ADDR_WIDTH-1:0] write_addr;
        logic                      reg_write;
        logic                      jump_reg;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e state_q, state_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    entry_t in_entry;
    logic   accept;
    logic   drain;

    // A write to $0 is architecturally a no-op, so it is dropped at capture time.
    function automatic entry_t capture(input entry_t e);
        entry_t c;
        c = e;
        if (ZERO_REG_SUPP && (e.write_addr == '0)) begin
            c.reg_write = 1'b0;
        end
        return c;
    endfunction

    always_comb begin
        in_entry            = '0;
        in_entry.pc         = in_pc;
        in_entry.zero       = in_zero;
        in_entry.result     = in_result;
        in_entry.data2      = in_data2;
        in_entry.write_addr = in_write_addr;
        in_entry.reg_write  = in_reg_write;
        in_entry.jump_reg   = in_jump_reg;
    end

    assign accept = in_valid && in_ready;
    assign drain  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // Flush squashes both held entries and the incoming one; payload is left as is.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = ONE;
                        main_d  = capture(in_entry);
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        main_d = capture(in_entry);
                    end else if (accept) begin
                        state_d = FULL;
                        skid_d  = capture(in_entry);
                    end else if (drain) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (drain) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // in_ready depends only on registered state and rst, never on out_ready.
    always_comb begin
        out_valid      = (state_q != EMPTY);
        in_ready       = (state_q != FULL) && !rst;
        out_reg_write  = main_q.reg_write && out_valid;
        out_jump_reg   = main_q.jump_reg && out_valid;
        out_pc         = main_q.pc;
        out_zero       = main_q.zero;
        out_result     = main_q.result;
        out_data2      = main_q.data2;
        out_write_addr = main_q.write_addr;
    end

endmodule
